// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
//
// Shared definitions for the branch-predictor update controller:
//   BP_INDEX_W     default table index width (table holds 2^BP_INDEX_W counters)
//   bp_ctr_t       2-bit saturating prediction counter
//   bp_state_t     controller state (BP_INIT sweep, BP_RUN update retire)
//   BP_INIT_STATE  counter value written by the init sweep (weakly not-taken)
//   bp_next_ctr()  counter update from the old value and the "correct" flag
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int BP_INDEX_W = 7;

   typedef logic [1:0] bp_ctr_t;

   typedef enum logic {
      BP_INIT = 1'b0,
      BP_RUN  = 1'b1
   } bp_state_t;

   localparam bp_ctr_t BP_INIT_STATE = 2'b01;

   // A correct prediction pushes the counter to the strong end of the
   // direction it already predicts. A wrong prediction moves it one step
   // towards the opposite direction, so a strong counter becomes weak and
   // a weak counter flips to the weak state of the other direction.
   function automatic bp_ctr_t bp_next_ctr(input bp_ctr_t old_ctr, input logic correct);
      bp_ctr_t nxt;
      if (correct) begin
         nxt = old_ctr[1] ? 2'b11 : 2'b00;
      end else begin
         case (old_ctr)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b10;
            2'b10:   nxt = 2'b01;
            default: nxt = 2'b10;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
//
// Small FIFO of pending branch-resolution updates, each entry holding the
// table index and the "prediction was correct" flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop every entry (wins over push and pop)
//   push, push_idx,     enqueue one entry; ignored when full
//   push_correct
//   pop                 dequeue the head; ignored when empty
//   head_idx,           head entry, valid whenever empty is low
//   head_correct
//   full, empty         occupancy flags
//
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// that differ only in the wrap bit mean full. DEPTH must be a power of two
// and at least 2 so the low pointer bits index the storage directly.
// ---------------------------------------------------------------------------
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int INDEX_W = BP_INDEX_W,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               push,
   input  logic [INDEX_W-1:0] push_idx,
   input  logic               push_correct,
   input  logic               pop,
   output logic [INDEX_W-1:0] head_idx,
   output logic               head_correct,
   output logic               full,
   output logic               empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   typedef struct packed {
      logic [INDEX_W-1:0] idx;
      logic               correct;
   } entry_t;

   entry_t           mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic             do_push;
   logic             do_pop;
   entry_t           head_entry;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg[AW-1:0]] <= '{idx: push_idx, correct: push_correct};
      end
   end

   // The head is read combinationally so the controller can pop, read the
   // table and register the write all in one cycle.
   assign head_entry   = mem_reg[rd_ptr_reg[AW-1:0]];
   assign head_idx     = head_entry.idx;
   assign head_correct = head_entry.correct;

endmodule

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
//
// Sequences the 2-bit branch-prediction counter table. After reset or a
// clear request it sweeps every entry to INIT_STATE; afterwards it retires
// buffered ROB resolution results as one read-modify-write per cycle.
//
// Ports:
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   rdy_in                 global enable; low freezes all state
//   clear_in               re-initialise the table (flushes pending updates)
//   rob_bp_en_in           resolution update valid
//   rob_bp_correct_in      1 = prediction was correct
//   rob_bp_pc_in           PC of the resolved branch (index = pc[INDEX_W+1:2])
//   bp_rob_ready_out       update accepted this cycle when high
//   bp_busy_out            init sweep running; lookups must force not-taken
//   tbl_raddr_out          combinational table read index (FIFO head)
//   tbl_rdata_in           counter stored at tbl_raddr_out
//   tbl_we_out,            registered table write port
//   tbl_waddr_out,
//   tbl_wdata_out
//   stat_correct_out,      (BP_UPDATE_STATS_EN only) saturating counts of
//   stat_miss_out          retired correct / mispredicted updates
//
// Build option: define BP_UPDATE_STATS_EN to add the statistics counters
// and their output ports.
// ---------------------------------------------------------------------------
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int         INDEX_W    = BP_INDEX_W,
   parameter int         ADDR_W     = 32,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] INIT_STATE = BP_INIT_STATE
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rdy_in,
   input  logic               clear_in,
   input  logic               rob_bp_en_in,
   input  logic               rob_bp_correct_in,
   input  logic [ADDR_W-1:0]  rob_bp_pc_in,
   output logic               bp_rob_ready_out,
   output logic               bp_busy_out,
   output logic [INDEX_W-1:0] tbl_raddr_out,
   input  logic [1:0]         tbl_rdata_in,
   output logic               tbl_we_out,
   output logic [INDEX_W-1:0] tbl_waddr_out,
   output logic [1:0]         tbl_wdata_out
`ifdef BP_UPDATE_STATS_EN
   ,
   output logic [31:0]        stat_correct_out,
   output logic [31:0]        stat_miss_out
`endif
);

   bp_state_t          state_reg;
   bp_state_t          state_next;
   logic [INDEX_W-1:0] sweep_idx_reg;
   logic [INDEX_W-1:0] sweep_idx_next;
   logic               we_reg;
   logic               we_next;
   logic [INDEX_W-1:0] waddr_reg;
   logic [INDEX_W-1:0] waddr_next;
   bp_ctr_t            wdata_reg;
   bp_ctr_t            wdata_next;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [INDEX_W-1:0] head_idx;
   logic               head_correct;
   logic [INDEX_W-1:0] push_idx;
   bp_ctr_t            old_ctr;

   // PC bits outside the index field carry no information for the table.
   logic               unused_pc_bits;
   assign unused_pc_bits = ^{rob_bp_pc_in[ADDR_W-1:INDEX_W+2], rob_bp_pc_in[1:0]};

   assign push_idx = rob_bp_pc_in[INDEX_W+1:2];

   // -----------------------------------------------------------------------
   // ROB handshake. The reset term keeps ready low while reset is asserted,
   // even though the FIFO already reads empty.
   // -----------------------------------------------------------------------
   assign bp_rob_ready_out = rst_n_in && rdy_in && !fifo_full && !clear_in;
   assign fifo_push        = rob_bp_en_in && bp_rob_ready_out;

   bp_upd_fifo #(
      .INDEX_W (INDEX_W),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk_in),
      .rst_n        (rst_n_in),
      .flush        (fifo_flush),
      .push         (fifo_push),
      .push_idx     (push_idx),
      .push_correct (rob_bp_correct_in),
      .pop          (fifo_pop),
      .head_idx     (head_idx),
      .head_correct (head_correct),
      .full         (fifo_full),
      .empty        (fifo_empty)
   );

   assign tbl_raddr_out = head_idx;

   // The table only sees a registered write one cycle after it was
   // computed, so a pop of the index being written right now must take the
   // in-flight value instead of the stale table contents.
   assign old_ctr = (we_reg && (waddr_reg == head_idx)) ? wdata_reg : tbl_rdata_in;

   // -----------------------------------------------------------------------
   // Next-state / write-port logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      sweep_idx_next = sweep_idx_reg;
      we_next        = 1'b0;
      waddr_next     = waddr_reg;
      wdata_next     = wdata_reg;
      fifo_pop       = 1'b0;
      fifo_flush     = 1'b0;

      if (rdy_in) begin
         if (clear_in) begin
            // A write registered last cycle is already on the port and
            // still lands; nothing new is registered this cycle.
            fifo_flush     = 1'b1;
            sweep_idx_next = '0;
            state_next     = BP_INIT;
         end else if (state_reg == BP_INIT) begin
            we_next        = 1'b1;
            waddr_next     = sweep_idx_reg;
            wdata_next     = INIT_STATE;
            sweep_idx_next = sweep_idx_reg + 1'b1;
            if (sweep_idx_reg == {INDEX_W{1'b1}}) begin
               state_next = BP_RUN;
            end
         end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            we_next    = 1'b1;
            waddr_next = head_idx;
            wdata_next = bp_next_ctr(old_ctr, head_correct);
         end
      end
   end

   // Leaving BP_INIT happens on the same edge that registers the last sweep
   // write, so busy drops exactly when the final sweep write is presented.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg     <= BP_INIT;
         sweep_idx_reg <= '0;
         we_reg        <= 1'b0;
         waddr_reg     <= '0;
         wdata_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         sweep_idx_reg <= sweep_idx_next;
         we_reg        <= we_next;
         waddr_reg     <= waddr_next;
         wdata_reg     <= wdata_next;
      end
   end

   assign bp_busy_out   = (state_reg == BP_INIT);
   assign tbl_we_out    = we_reg;
   assign tbl_waddr_out = waddr_reg;
   assign tbl_wdata_out = wdata_reg;

`ifdef BP_UPDATE_STATS_EN
   // -----------------------------------------------------------------------
   // Retired-update statistics, saturating, cleared with the table.
   // -----------------------------------------------------------------------
   logic [31:0] stat_correct_reg;
   logic [31:0] stat_miss_reg;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stat_correct_reg <= '0;
         stat_miss_reg    <= '0;
      end else if (rdy_in && clear_in) begin
         stat_correct_reg <= '0;
         stat_miss_reg    <= '0;
      end else if (fifo_pop) begin
         if (head_correct) begin
            if (stat_correct_reg != 32'hFFFF_FFFF) begin
               stat_correct_reg <= stat_correct_reg + 32'd1;
            end
         end else begin
            if (stat_miss_reg != 32'hFFFF_FFFF) begin
               stat_miss_reg <= stat_miss_reg + 32'd1;
            end
         end
      end
   end

   assign stat_correct_out = stat_correct_reg;
   assign stat_miss_out    = stat_miss_reg;
`endif

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Controller that sequences the 2-bit branch-prediction counter table.
- Sweeps the table to a known state after reset or clear; lookups are flagged unusable while the sweep runs.
- Buffers ROB branch-resolution results in a small FIFO and retires at most one read-modify-write per cycle through the table's write port.
- Sits between the reorder buffer and the predictor table, in the same clock domain.

Parameters:
- INDEX_W, 7, table index width; table holds 2^INDEX_W counters; index = pc[INDEX_W+1:2].
- ADDR_W, 32, PC width.
- FIFO_DEPTH, 4, pending-update entries; power of two, at least 2.
- INIT_STATE, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- clear_in  in  1  request to re-initialise the table.
- rob_bp_en_in  in  1  resolution-update valid.
- rob_bp_correct_in  in  1  1 = prediction was correct.
- rob_bp_pc_in  in  ADDR_W  PC of the resolved branch.
- bp_rob_ready_out  in/out: out  1  update accepted this cycle when high.
- bp_busy_out  out  1  init sweep in progress; the lookup side forces not-taken while high.
- tbl_raddr_out  out  INDEX_W  read index (combinational read of the table).
- tbl_rdata_in  in  2  counter at tbl_raddr_out.
- tbl_we_out  out  1  registered write enable.
- tbl_waddr_out  out  INDEX_W  registered write index.
- tbl_wdata_out  out  2  registered write data.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - state = INIT, sweep index = 0, FIFO empty, write registers cleared.
  - Outputs: tbl_we_out = 0, tbl_waddr_out = 0, tbl_wdata_out = 0, bp_busy_out = 1, bp_rob_ready_out = 0.
- rdy_in low: no state change, no push, no pop. tbl_we_out deasserts at the next edge. bp_rob_ready_out = 0.
- bp_rob_ready_out = rdy_in && !fifo_full && !clear_in.
- Push occurs when rob_bp_en_in && bp_rob_ready_out. An update presented while ready is low is dropped; the ROB must hold it.
- INIT state:
  - Each rdy cycle, registers a write {index = sweep idx, data = INIT_STATE}, then increments sweep idx.
  - After the write of index 2^INDEX_W-1 is registered, go to RUN. bp_busy_out falls in the same cycle tbl_we_out carries the last index.
  - Pushes are accepted during INIT; pops are not.
- RUN state:
  - If the FIFO is non-empty and rdy_in is high, pop the head.
  - tbl_raddr_out = head index.
  - Compute next = f(old, correct); register {we = 1, waddr, wdata = next}. Table sees the write one cycle after the pop.
- Next-state function:
  - correct: 00→00, 01→00, 10→11, 11→11.
  - wrong: 00→01, 01→10, 10→01, 11→10.
- Bypass: if the popped index equals the registered tbl_waddr_out while tbl_we_out = 1, old = tbl_wdata_out instead of tbl_rdata_in. Back-to-back same-index updates therefore chain correctly.
- Push and pop in the same cycle are legal when the FIFO is non-full; occupancy is unchanged.
- FIFO pointers are INDEX-free, log2(FIFO_DEPTH)+1 bits wide; full/empty come from the MSB compare; pointers wrap naturally.
- clear_in (rdy high), from either state:
  - FIFO flushed, sweep idx = 0, state = INIT.
  - A push offered in the same cycle is not accepted.
  - A write already registered still completes.
  - clear_in during INIT restarts the sweep at 0.

Optional Feature:
- Macro BP_UPDATE_STATS_EN.
- Defined: adds outputs stat_correct_out [31:0] and stat_miss_out [31:0]. Each counts popped updates by the correct flag, saturates at 0xFFFFFFFF, and is cleared by reset and by clear_in.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - BP_INDEX_W, typedef bp_ctr_t (logic[1:0]).
  - State enum {BP_INIT, BP_RUN}, BP_INIT_STATE.
  - Function bp_next_ctr(bp_ctr_t, logic correct).
- One sub-module, bp_upd_fifo: the update FIFO (push/pop, flush, full/empty), storing {index, correct}.

Test Plan:
- Release reset with rdy_in = 1: bp_busy_out high for 128 cycles; writes to indices 0..127 with data 01 in order; first free cycle after that has bp_busy_out = 0 and tbl_we_out = 0.
- After init, push pc = 0x1004, correct = 0 → pop reads index 1 (01); the next cycle shows we = 1, waddr = 1, wdata = 10.
- Back-to-back pushes pc = 0x1004 wrong, then pc = 0x1004 correct (table holds 01) → writes 10, then 11 via bypass, not 00.
- During INIT, push 4 updates → bp_rob_ready_out low; a 5th en is not accepted. After the sweep, the 4 updates are written in push order on 4 consecutive cycles.
- In RUN with 2 pending updates, assert clear_in for one cycle → FIFO empty, bp_busy_out = 1, next write is index 0 with data 01, and the pending updates are never written.
- Mid-INIT at sweep idx 40, drop rdy_in for 3 cycles → no writes during the gap; sweep resumes at idx 40. Async reset asserted mid-RUN → tbl_we_out = 0 immediately and the sweep restarts at 0.
